ex_mem_stage: RTL and testbench



---
 rtl/ex_mem_if.sv | 48 ++++
 rtl/ex_mem_stage.sv | 184 ++++++++++++++++++
 tb/tb_ex_mem_stage.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/ex_mem_if.sv
// EX-side inputs and MEM-side outputs of the execute/memory slice.
// The stage itself uses the slave view; the upstream ID/EX and downstream MEM/WB logic use the master view.
interface ex_mem_if;
    logic [7:0]  ex_data_1;
    logic [7:0]  ex_data_2;
    logic [7:0]  ex_imm;
    logic [2:0]  ex_dest;
    logic [11:0] ex_new_pc;
    logic        ex_is_shift;
    logic        ex_alu_src;
    logic        ex_update_z_c;
    logic [1:0]  ex_scode;
    logic [2:0]  ex_acode;
    logic        ex_mem_write;
    logic [1:0]  ex_pc_src;
    logic        ex_mem_or_alu;
    logic        ex_reg_write;

    logic        zero;
    logic        carry;
    logic [11:0] mem_branch_pc;
    logic [7:0]  mem_alu_result;
    logic [7:0]  mem_store_data;
    logic [2:0]  mem_dest;
    logic [1:0]  mem_pc_src;
    logic        mem_mem_write;
    logic        mem_mem_or_alu;
    logic        mem_reg_write;
    logic [7:0]  mem_read_data;

    modport slave (
        input  ex_data_1, ex_data_2, ex_imm, ex_dest, ex_new_pc,
               ex_is_shift, ex_alu_src, ex_update_z_c, ex_scode, ex_acode,
               ex_mem_write, ex_pc_src, ex_mem_or_alu, ex_reg_write,
        output zero, carry, mem_branch_pc, mem_alu_result, mem_store_data,
               mem_dest, mem_pc_src, mem_mem_write, mem_mem_or_alu,
               mem_reg_write, mem_read_data
    );

    modport master (
        output ex_data_1, ex_data_2, ex_imm, ex_dest, ex_new_pc,
               ex_is_shift, ex_alu_src, ex_update_z_c, ex_scode, ex_acode,
               ex_mem_write, ex_pc_src, ex_mem_or_alu, ex_reg_write,
        input  zero, carry, mem_branch_pc, mem_alu_result, mem_store_data,
               mem_dest, mem_pc_src, mem_mem_write, mem_mem_or_alu,
               mem_reg_write, mem_read_data
    );
endinterface

// File: rtl/ex_mem_stage.sv
// Execute + memory slice of the 8-bit pipeline: ALU with Z/C flags, branch adder,
// EX/MEM pipeline register and a 256x8 data memory with combinational read.
module ex_mem_stage (
    input  logic     clk,
    input  logic     rst,
    ex_mem_if.slave  bus
);

    typedef enum logic [2:0] {
        ACODE_ADD  = 3'b000,
        ACODE_ADC  = 3'b001,
        ACODE_SUB  = 3'b010,
        ACODE_SBC  = 3'b011,
        ACODE_AND  = 3'b100,
        ACODE_OR   = 3'b101,
        ACODE_XOR  = 3'b110,
        ACODE_PASS = 3'b111
    } acode_e;

    typedef enum logic [1:0] {
        SCODE_SHL = 2'b00,
        SCODE_SHR = 2'b01,
        SCODE_ROL = 2'b10,
        SCODE_ROR = 2'b11
    } scode_e;

    // Pipeline and flag state.
    logic        zero_q,        zero_d;
    logic        carry_q,       carry_d;
    logic [11:0] branch_pc_q,   branch_pc_d;
    logic [7:0]  alu_result_q,  alu_result_d;
    logic [7:0]  store_data_q,  store_data_d;
    logic [2:0]  dest_q,        dest_d;
    logic [1:0]  pc_src_q,      pc_src_d;
    logic        mem_write_q,   mem_write_d;
    logic        mem_or_alu_q,  mem_or_alu_d;
    logic        reg_write_q,   reg_write_d;

    logic [7:0]  mem_q [256];

    // Combinational datapath.
    logic [7:0]  operand_a;
    logic [7:0]  operand_b;
    logic [2:0]  shamt;
    logic [7:0]  alu_result;
    logic        alu_carry;
    logic [8:0]  arith_wide;
    logic [8:0]  shl_wide;
    logic [8:0]  shr_wide;
    logic [7:0]  rol_result;
    logic [7:0]  ror_result;
    logic [11:0] branch_target;

    assign operand_a = bus.ex_data_1;

    // Immediate wins over the shift-amount field when both selects are set.
    assign operand_b = bus.ex_alu_src  ? bus.ex_imm :
                       bus.ex_is_shift ? {5'b0, bus.ex_imm[7:5]} :
                                         bus.ex_data_2;

    assign shamt = operand_b[2:0];

    assign branch_target = bus.ex_new_pc + {{4{bus.ex_imm[7]}}, bus.ex_imm};

    always_comb begin
        // NOTE: every signal gets a default before the case logic so no path leaves a latch behind.
        alu_result = 8'h00;
        alu_carry  = 1'b0;
        arith_wide = 9'h000;
        shl_wide   = {1'b0, operand_a} << shamt;
        shr_wide   = {operand_a, 1'b0} >> shamt;
        rol_result = (operand_a << shamt) | (operand_a >> (4'd8 - {1'b0, shamt}));
        ror_result = (operand_a >> shamt) | (operand_a << (4'd8 - {1'b0, shamt}));

        if (bus.ex_is_shift) begin
            unique case (scode_e'(bus.ex_scode))
                SCODE_SHL: begin
                    alu_result = shl_wide[7:0];
                    alu_carry  = shl_wide[8];
                end
                SCODE_SHR: begin
                    alu_result = shr_wide[8:1];
                    alu_carry  = shr_wide[0];
                end
                SCODE_ROL: begin
                    alu_result = rol_result;
                    alu_carry  = rol_result[0];
                end
                SCODE_ROR: begin
                    alu_result = ror_result;
                    alu_carry  = ror_result[7];
                end
                default: ;
            endcase
            if (shamt == 3'd0) begin
                alu_result = operand_a;
                alu_carry  = 1'b0;
            end
        end else begin
            // Subtractions keep bit 8 of the 9-bit difference as the borrow.
            unique case (acode_e'(bus.ex_acode))
                ACODE_ADD: arith_wide = {1'b0, operand_a} + {1'b0, operand_b};
                ACODE_ADC: arith_wide = {1'b0, operand_a} + {1'b0, operand_b} + {8'h00, carry_q};
                ACODE_SUB: arith_wide = {1'b0, operand_a} - {1'b0, operand_b};
                ACODE_SBC: arith_wide = {1'b0, operand_a} - {1'b0, operand_b} - {8'h00, carry_q};
                ACODE_AND: arith_wide = {1'b0, operand_a & operand_b};
                ACODE_OR:  arith_wide = {1'b0, operand_a | operand_b};
                ACODE_XOR: arith_wide = {1'b0, operand_a ^ operand_b};
                ACODE_PASS: arith_wide = {1'b0, operand_b};
                default: ;
            endcase
            alu_result = arith_wide[7:0];
            alu_carry  = arith_wide[8];
        end
    end

    always_comb begin
        zero_d       = zero_q;
        carry_d      = carry_q;
        if (bus.ex_update_z_c) begin
            zero_d  = (alu_result == 8'h00);
            carry_d = alu_carry;
        end
        branch_pc_d  = branch_target;
        alu_result_d = alu_result;
        store_data_d = bus.ex_data_2;
        dest_d       = bus.ex_dest;
        pc_src_d     = bus.ex_pc_src;
        mem_write_d  = bus.ex_mem_write;
        mem_or_alu_d = bus.ex_mem_or_alu;
        reg_write_d  = bus.ex_reg_write;
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            zero_q       <= 1'b0;
            carry_q      <= 1'b0;
            branch_pc_q  <= 12'h000;
            alu_result_q <= 8'h00;
            store_data_q <= 8'h00;
            dest_q       <= 3'd0;
            pc_src_q     <= 2'd0;
            mem_write_q  <= 1'b0;
            mem_or_alu_q <= 1'b0;
            reg_write_q  <= 1'b0;
        end else begin
            zero_q       <= zero_d;
            carry_q      <= carry_d;
            branch_pc_q  <= branch_pc_d;
            alu_result_q <= alu_result_d;
            store_data_q <= store_data_d;
            dest_q       <= dest_d;
            pc_src_q     <= pc_src_d;
            mem_write_q  <= mem_write_d;
            mem_or_alu_q <= mem_or_alu_d;
            reg_write_q  <= reg_write_d;
        end
    end

    // NOTE: the memory must read as zero after reset, so it is built from resettable flops rather than a RAM macro.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) begin
                mem_q[i] <= 8'h00;
            end
        end else if (mem_write_q) begin
            mem_q[alu_result_q] <= store_data_q;
        end
    end

    assign bus.zero           = zero_q;
    assign bus.carry          = carry_q;
    assign bus.mem_branch_pc  = branch_pc_q;
    assign bus.mem_alu_result = alu_result_q;
    assign bus.mem_store_data = store_data_q;
    assign bus.mem_dest       = dest_q;
    assign bus.mem_pc_src     = pc_src_q;
    assign bus.mem_mem_write  = mem_write_q;
    assign bus.mem_mem_or_alu = mem_or_alu_q;
    assign bus.mem_reg_write  = reg_write_q;
    assign bus.mem_read_data  = mem_q[alu_result_q];

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed bench for ex_mem_stage: drives EX fields, samples mem_* outputs 1 ns after each edge.
module tb_ex_mem_stage;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;

    ex_mem_if bus ();

    ex_mem_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end else begin
            n_pass++;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] a, input logic [7:0] d2, input logic [7:0] imm,
                         input logic alu_src, input logic is_shift, input logic [1:0] scode,
                         input logic [2:0] acode, input logic upd, input logic mw);
        bus.ex_data_1     = a;
        bus.ex_data_2     = d2;
        bus.ex_imm        = imm;
        bus.ex_alu_src    = alu_src;
        bus.ex_is_shift   = is_shift;
        bus.ex_scode      = scode;
        bus.ex_acode      = acode;
        bus.ex_update_z_c = upd;
        bus.ex_mem_write  = mw;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst = 1'b1;
        bus.ex_dest       = 3'd0;
        bus.ex_new_pc     = 12'h000;
        bus.ex_pc_src     = 2'd0;
        bus.ex_mem_or_alu = 1'b0;
        bus.ex_reg_write  = 1'b0;
        drive(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 2'b00, 3'b000, 1'b0, 1'b0);
        step();
        step();
        check("init_result", bus.mem_alu_result, 8'h00);
        check("init_zero", bus.zero, 1'b0);
        check("init_carry", bus.carry, 1'b0);
        check("init_read", bus.mem_read_data, 8'h00);

        // Preload 0x77 at 0x10 with a PASS-imm store.
        rst = 1'b0;
        drive(8'h00, 8'h77, 8'h10, 1'b1, 1'b0, 2'b00, 3'b111, 1'b1, 1'b1);
        step();
        check("store_pending", bus.mem_mem_write, 1'b1);
        check("store_old_read", bus.mem_read_data, 8'h00);

        // ADD 0xF0+0x20 lands on address 0x10 just as the store commits.
        drive(8'hF0, 8'h20, 8'h00, 1'b0, 1'b0, 2'b00, 3'b000, 1'b1, 1'b0);
        step();
        check("add_result", bus.mem_alu_result, 8'h10);
        check("add_carry", bus.carry, 1'b1);
        check("add_zero", bus.zero, 1'b0);
        check("preload_read", bus.mem_read_data, 8'h77);

        drive(8'h01, 8'h01, 8'h00, 1'b0, 1'b0, 2'b00, 3'b001, 1'b1, 1'b0);
        step();
        check("adc_result", bus.mem_alu_result, 8'h03);
        check("adc_carry", bus.carry, 1'b0);

        drive(8'hF0, 8'h20, 8'h00, 1'b0, 1'b0, 2'b00, 3'b000, 1'b1, 1'b0);
        bus.ex_dest   = 3'd6;
        bus.ex_pc_src = 2'd2;
        step();
        check("add2_carry", bus.carry, 1'b1);

        // Reset with a pending flag update: reset must win.
        rst = 1'b1;
        step();
        check("rst_result", bus.mem_alu_result, 8'h00);
        check("rst_store", bus.mem_store_data, 8'h00);
        check("rst_dest", bus.mem_dest, 3'd0);
        check("rst_pc_src", bus.mem_pc_src, 2'd0);
        check("rst_branch", bus.mem_branch_pc, 12'h000);
        check("rst_zero", bus.zero, 1'b0);
        check("rst_carry", bus.carry, 1'b0);
        check("rst_read0", bus.mem_read_data, 8'h00);
        rst = 1'b0;
        bus.ex_dest   = 3'd0;
        bus.ex_pc_src = 2'd0;
        drive(8'h00, 8'h00, 8'h10, 1'b1, 1'b0, 2'b00, 3'b111, 1'b0, 1'b0);
        step();
        check("rst_read10", bus.mem_read_data, 8'h00);

        // Subtract: equal operands via immediate, then a borrow, then SBC using that borrow.
        drive(8'h05, 8'h00, 8'h05, 1'b1, 1'b0, 2'b00, 3'b010, 1'b1, 1'b0);
        step();
        check("sub_eq_result", bus.mem_alu_result, 8'h00);
        check("sub_eq_zero", bus.zero, 1'b1);
        check("sub_eq_carry", bus.carry, 1'b0);
        drive(8'h03, 8'h05, 8'h00, 1'b0, 1'b0, 2'b00, 3'b010, 1'b1, 1'b0);
        step();
        check("sub_bor_result", bus.mem_alu_result, 8'hFE);
        check("sub_bor_carry", bus.carry, 1'b1);
        check("sub_bor_zero", bus.zero, 1'b0);
        drive(8'h10, 8'h01, 8'h00, 1'b0, 1'b0, 2'b00, 3'b011, 1'b1, 1'b0);
        step();
        check("sbc_result", bus.mem_alu_result, 8'h0E);
        check("sbc_carry", bus.carry, 1'b0);

        // Shifts of 0x81 by 1 (imm[7:5] = 1).
        drive(8'h81, 8'h00, 8'h20, 1'b0, 1'b1, 2'b00, 3'b000, 1'b1, 1'b0);
        step();
        check("shl_result", bus.mem_alu_result, 8'h02);
        check("shl_carry", bus.carry, 1'b1);
        drive(8'h81, 8'h00, 8'h20, 1'b0, 1'b1, 2'b01, 3'b000, 1'b1, 1'b0);
        step();
        check("shr_result", bus.mem_alu_result, 8'h40);
        check("shr_carry", bus.carry, 1'b1);
        drive(8'h81, 8'h00, 8'h20, 1'b0, 1'b1, 2'b10, 3'b000, 1'b1, 1'b0);
        step();
        check("rol_result", bus.mem_alu_result, 8'h03);
        check("rol_carry", bus.carry, 1'b1);
        drive(8'h81, 8'h00, 8'h20, 1'b0, 1'b1, 2'b11, 3'b000, 1'b1, 1'b0);
        step();
        check("ror_result", bus.mem_alu_result, 8'hC0);
        check("ror_carry", bus.carry, 1'b1);

        // Flags hold when update is low even though the result is zero.
        drive(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 2'b00, 3'b000, 1'b0, 1'b0);
        step();
        check("hold_result", bus.mem_alu_result, 8'h00);
        check("hold_zero", bus.zero, 1'b0);
        check("hold_carry", bus.carry, 1'b1);

        drive(8'h81, 8'h00, 8'h00, 1'b0, 1'b1, 2'b00, 3'b000, 1'b1, 1'b0);
        step();
        check("sh0_result", bus.mem_alu_result, 8'h81);
        check("sh0_carry", bus.carry, 1'b0);

        // alu_src beats is_shift: amount comes from imm[2:0] = 1.
        drive(8'h81, 8'h00, 8'h01, 1'b1, 1'b1, 2'b00, 3'b000, 1'b1, 1'b0);
        step();
        check("prio_result", bus.mem_alu_result, 8'h02);

        // Store 0xA5 to 0x3C, let it commit, then load it back.
        bus.ex_dest = 3'd5;
        drive(8'h00, 8'hA5, 8'h3C, 1'b1, 1'b0, 2'b00, 3'b111, 1'b0, 1'b1);
        step();
        check("st_data", bus.mem_store_data, 8'hA5);
        check("st_dest", bus.mem_dest, 3'd5);
        check("st_old_read", bus.mem_read_data, 8'h00);
        drive(8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 2'b00, 3'b111, 1'b0, 1'b0);
        step();
        bus.ex_mem_or_alu = 1'b1;
        bus.ex_reg_write  = 1'b1;
        drive(8'h00, 8'h00, 8'h3C, 1'b1, 1'b0, 2'b00, 3'b111, 1'b0, 1'b0);
        step();
        check("ld_read", bus.mem_read_data, 8'hA5);
        check("ld_mem_or_alu", bus.mem_mem_or_alu, 1'b1);
        check("ld_reg_write", bus.mem_reg_write, 1'b1);
        bus.ex_mem_or_alu = 1'b0;
        bus.ex_reg_write  = 1'b0;

        // Overwrite 0x3C: old value visible until the committing edge.
        drive(8'h00, 8'h5A, 8'h3C, 1'b1, 1'b0, 2'b00, 3'b111, 1'b0, 1'b1);
        step();
        check("wr_same_cycle_old", bus.mem_read_data, 8'hA5);
        drive(8'h00, 8'h00, 8'h3D, 1'b1, 1'b0, 2'b00, 3'b111, 1'b0, 1'b0);
        step();
        check("ld_neighbor", bus.mem_read_data, 8'h00);
        drive(8'h00, 8'h00, 8'h3C, 1'b1, 1'b0, 2'b00, 3'b111, 1'b0, 1'b0);
        step();
        check("ld_new", bus.mem_read_data, 8'h5A);

        // Branch targets, including negative offset and 12-bit wrap.
        bus.ex_new_pc = 12'h010;
        bus.ex_pc_src = 2'b11;
        drive(8'h00, 8'h00, 8'hFE, 1'b1, 1'b0, 2'b00, 3'b111, 1'b0, 1'b0);
        step();
        check("br_back", bus.mem_branch_pc, 12'h00E);
        check("br_pc_src", bus.mem_pc_src, 2'b11);
        bus.ex_new_pc = 12'hFFF;
        bus.ex_pc_src = 2'b00;
        drive(8'h00, 8'h00, 8'h02, 1'b1, 1'b0, 2'b00, 3'b111, 1'b0, 1'b0);
        step();
        check("br_wrap", bus.mem_branch_pc, 12'h001);
        check("br_pc_src0", bus.mem_pc_src, 2'b00);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
